// File: rtl/cdb_sched.sv
// Common data bus scheduler: per-port 2-deep result queues, fixed-priority pick with
// a starvation override, and a registered CDB broadcast that flush/rst can cancel.
module cdb_sched #(
  parameter int NUM_REQ    = 3,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 6,
  parameter int STARVE_MAX = 4,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WAIT_W    = $clog2(STARVE_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        rdy,
  input  logic [NUM_REQ*TAG_W-1:0]  tag,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ*ID_W-1:0]   inst_id,
  output logic                      cdb_wr,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_wdata,
  output logic [ID_W-1:0]           cdb_inst_id,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [TAG_W-1:0]  q_tag  [NUM_REQ][2];
  logic [DATA_W-1:0] q_data [NUM_REQ][2];
  logic [ID_W-1:0]   q_id   [NUM_REQ][2];
  logic [1:0]        cnt    [NUM_REQ];
  logic [WAIT_W-1:0] wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] rd_ptr, wr_ptr;

  logic [NUM_REQ-1:0] cand, starve, gnt, enq;
  logic               gnt_any;
  logic [SRC_W-1:0]   gnt_idx;
  logic [TAG_W-1:0]   head_tag;
  logic [DATA_W-1:0]  head_data;
  logic [ID_W-1:0]    head_id;

  // Handshake: port i transfers at the edge where req[i] && rdy[i]. rdy depends only on
  // registered occupancy, rst and flush (never on req), so a producer may hold req high
  // with stable fields until it sees rdy.
  always_comb begin
    rdy     = '0;
    cand    = '0;
    starve  = '0;
    enq     = '0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    head_tag  = '0;
    head_data = '0;
    head_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rdy[i]    = ~rst & ~flush & (cnt[i] < 2'd2);
      cand[i]   = (cnt[i] != 2'd0);
      starve[i] = cand[i] && (wait_cnt[i] == WAIT_W'(STARVE_MAX));
      enq[i]    = req[i] & rdy[i];
    end
    gnt_any = |cand;
    // Descending scans so the lowest matching index is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) gnt_idx = SRC_W'(i);
    end
    if (|starve) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (starve[i]) gnt_idx = SRC_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && (gnt_idx == SRC_W'(i))) begin
        gnt[i]    = 1'b1;
        head_tag  = q_tag[i][rd_ptr[i]];
        head_data = q_data[i][rd_ptr[i]];
        head_id   = q_id[i][rd_ptr[i]];
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enq[i]) begin
        q_tag[i][wr_ptr[i]]  <= tag[i*TAG_W +: TAG_W];
        q_data[i][wr_ptr[i]] <= wdata[i*DATA_W +: DATA_W];
        q_id[i][wr_ptr[i]]   <= inst_id[i*ID_W +: ID_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i]      <= 2'd0;
        wait_cnt[i] <= '0;
      end
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cdb_wr      <= 1'b0;
      cdb_tag     <= '0;
      cdb_wdata   <= '0;
      cdb_inst_id <= '0;
      cdb_src     <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i]      <= 2'd0;
        wait_cnt[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      cdb_wr <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({enq[i], gnt[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
        if (enq[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (gnt[i]) rd_ptr[i] <= ~rd_ptr[i];
        if (!cand[i] || gnt[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != WAIT_W'(STARVE_MAX)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
      cdb_wr <= gnt_any;
      if (gnt_any) begin
        cdb_tag     <= head_tag;
        cdb_wdata   <= head_data;
        cdb_inst_id <= head_id;
        cdb_src     <= gnt_idx;
      end
    end
  end

endmodule
